// File: rtl/exception_vector_unit_if.sv
// Bundles the exception flags, vector-fetch memory port and PC-select outputs of the exception vector unit.
// The master modport is the datapath/memory side; the slave modport is the unit itself.
interface exception_vector_unit_if;
  logic        exc_opcode;
  logic        exc_overflow;
  logic        exc_div0;
  logic [31:0] epc_in;
  logic [31:0] mem_data_in;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_addr_sel;
  logic [31:0] epc_out;
  logic [1:0]  cause;
  logic [31:0] handler_addr;
  logic [1:0]  ex_control;
  logic        pc_write;
  logic        busy;

  modport master (
    output exc_opcode, exc_overflow, exc_div0, epc_in, mem_data_in,
    input  mem_addr, mem_rd, mem_addr_sel, epc_out, cause, handler_addr,
           ex_control, pc_write, busy
  );

  modport slave (
    input  exc_opcode, exc_overflow, exc_div0, epc_in, mem_data_in,
    output mem_addr, mem_rd, mem_addr_sel, epc_out, cause, handler_addr,
           ex_control, pc_write, busy
  );
endinterface

// File: rtl/exception_vector_unit.sv
// MIPS multicycle exception entry: latch EPC/cause, fetch the vector byte, strobe the PC load; MEM_LATENCY+2 cycles busy.
// No backpressure: flags are sampled only in IDLE and ignored (not queued) while busy; all outputs are registered.
module exception_vector_unit #(
  parameter int VEC_OPCODE   = 253,
  parameter int VEC_OVERFLOW = 254,
  parameter int VEC_DIV0     = 255,
  parameter int MEM_LATENCY  = 2
) (
  input logic                    clk,
  input logic                    reset,
  exception_vector_unit_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SAVE = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_JUMP = 2'd3;

  localparam logic [2:0] CNT_LOAD = 3'(MEM_LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_addr_sel_q, mem_addr_sel_d;
  logic [31:0] epc_q, epc_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] handler_q, handler_d;
  logic [1:0]  ex_control_q, ex_control_d;
  logic        pc_write_q, pc_write_d;
  logic        busy_q, busy_d;

  logic        any_exc;
  logic [1:0]  new_cause;
  logic [31:0] new_vec;
  logic        unused_mem_bits;

  assign unused_mem_bits = ^bus.mem_data_in[31:8];
  assign any_exc = bus.exc_opcode | bus.exc_overflow | bus.exc_div0;

  // Fixed priority: opcode > overflow > div0.
  always_comb begin
    new_cause = 2'b00;
    new_vec   = 32'd0;
    if (bus.exc_opcode) begin
      new_cause = 2'b01;
      new_vec   = 32'(VEC_OPCODE);
    end else if (bus.exc_overflow) begin
      new_cause = 2'b10;
      new_vec   = 32'(VEC_OVERFLOW);
    end else if (bus.exc_div0) begin
      new_cause = 2'b11;
      new_vec   = 32'(VEC_DIV0);
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mem_addr_d     = mem_addr_q;
    mem_rd_d       = 1'b0;
    mem_addr_sel_d = mem_addr_sel_q;
    epc_d          = epc_q;
    cause_d        = cause_q;
    handler_d      = handler_q;
    ex_control_d   = 2'b00;
    pc_write_d     = 1'b0;
    busy_d         = busy_q;

    case (state_q)
      S_IDLE: begin
        busy_d         = 1'b0;
        mem_addr_sel_d = 1'b0;
        if (any_exc) begin
          epc_d          = bus.epc_in;
          cause_d        = new_cause;
          mem_addr_d     = new_vec;
          mem_rd_d       = 1'b1;
          mem_addr_sel_d = 1'b1;
          busy_d         = 1'b1;
          state_d        = S_SAVE;
        end
      end
      S_SAVE: begin
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          handler_d      = {24'd0, bus.mem_data_in[7:0]};
          ex_control_d   = 2'b01;
          pc_write_d     = 1'b1;
          mem_addr_sel_d = 1'b0;
          state_d        = S_JUMP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_JUMP: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d         = 1'b0;
        mem_addr_sel_d = 1'b0;
        state_d        = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= 3'd0;
      mem_addr_q     <= 32'd0;
      mem_rd_q       <= 1'b0;
      mem_addr_sel_q <= 1'b0;
      epc_q          <= 32'd0;
      cause_q        <= 2'b00;
      handler_q      <= 32'd0;
      ex_control_q   <= 2'b00;
      pc_write_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mem_addr_q     <= mem_addr_d;
      mem_rd_q       <= mem_rd_d;
      mem_addr_sel_q <= mem_addr_sel_d;
      epc_q          <= epc_d;
      cause_q        <= cause_d;
      handler_q      <= handler_d;
      ex_control_q   <= ex_control_d;
      pc_write_q     <= pc_write_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_rd       = mem_rd_q;
  assign bus.mem_addr_sel = mem_addr_sel_q;
  assign bus.epc_out      = epc_q;
  assign bus.cause        = cause_q;
  assign bus.handler_addr = handler_q;
  assign bus.ex_control   = ex_control_q;
  assign bus.pc_write     = pc_write_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_exception_vector_unit.sv
// Randomized bench for exception_vector_unit against a phase-count reference model, plus directed literal checks.
// A second instance with MEM_LATENCY=1 pins the shortened sequence.
module tb_exception_vector_unit;
  localparam int LAT = 2;

  logic clk;
  logic rst_n;

  exception_vector_unit_if bus ();
  exception_vector_unit_if bus1 ();

  exception_vector_unit #(.MEM_LATENCY(LAT)) u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  exception_vector_unit #(.MEM_LATENCY(1)) u_dut1 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: p = cycles since the trigger edge (0 = idle).
  int          p;
  logic [1:0]  m_cause;
  logic [31:0] m_epc, m_addr, m_hand;
  logic [31:0] vec_word [253:255];
  int          rd_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    p = 0; m_cause = 2'b00; m_epc = 32'd0; m_addr = 32'd0; m_hand = 32'd0; rd_cnt = 0;
  endtask

  task automatic model_advance(input logic op, input logic ov, input logic dv,
                               input logic [31:0] epc, input logic [31:0] md);
    if (p == 0) begin
      if (op || ov || dv) begin
        p       = 1;
        m_cause = op ? 2'd1 : (ov ? 2'd2 : 2'd3);
        m_epc   = epc;
        m_addr  = 32'd252 + 32'(m_cause);
      end
    end else if (p == LAT + 1) begin
      m_hand = {24'd0, md[7:0]};
      p++;
    end else if (p == LAT + 2) begin
      p = 0;
    end else begin
      p++;
    end
  endtask

  task automatic compare_all();
    chk("busy",         32'(bus.busy),         32'(p != 0));
    chk("mem_rd",       32'(bus.mem_rd),       32'(p == 1));
    chk("mem_addr_sel", 32'(bus.mem_addr_sel), 32'(p >= 1 && p <= LAT + 1));
    chk("ex_control",   32'(bus.ex_control),   (p == LAT + 2) ? 32'd1 : 32'd0);
    chk("pc_write",     32'(bus.pc_write),     32'(p == LAT + 2));
    chk("mem_addr",     bus.mem_addr,          m_addr);
    chk("epc_out",      bus.epc_out,           m_epc);
    chk("cause",        32'(bus.cause),        32'(m_cause));
    chk("handler_addr", bus.handler_addr,      m_hand);
  endtask

  // One clock: drive inputs and memory data, advance the model, then compare after the edge.
  task automatic step(input logic op, input logic ov, input logic dv, input logic [31:0] epc);
    logic [31:0] md;
    int idx;
    idx = int'(m_addr);
    if (rd_cnt == 1 && idx >= 253 && idx <= 255) md = vec_word[idx];
    else md = $urandom;
    if (bus.mem_rd) rd_cnt = LAT;
    else if (rd_cnt > 0) rd_cnt--;
    bus.exc_opcode   = op;
    bus.exc_overflow = ov;
    bus.exc_div0     = dv;
    bus.epc_in       = epc;
    bus.mem_data_in  = md;
    model_advance(op, ov, dv, epc, md);
    @(negedge clk);
    compare_all();
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int pcw;
    int jump_at;
    logic [2:0] f;
    logic [31:0] e;

    rst_n = 1'b0;
    bus.exc_opcode = 1'b0; bus.exc_overflow = 1'b0; bus.exc_div0 = 1'b0;
    bus.epc_in = 32'd0; bus.mem_data_in = 32'd0;
    bus1.exc_opcode = 1'b0; bus1.exc_overflow = 1'b0; bus1.exc_div0 = 1'b0;
    bus1.epc_in = 32'd0; bus1.mem_data_in = 32'd0;
    for (int i = 253; i <= 255; i++) vec_word[i] = $urandom;
    model_reset();

    repeat (2) @(negedge clk);
    chk("in_reset_busy", 32'(bus.busy), 32'd0);
    chk("in_reset_mem_addr", bus.mem_addr, 32'd0);
    rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, $urandom);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_ex_control", 32'(bus.ex_control), 32'd0);
    chk("idle_epc", bus.epc_out, 32'd0);

    // Overflow exception with known vector
    vec_word[254] = 32'h0000_00A4;
    step(1'b0, 1'b1, 1'b0, 32'h0000_0040);
    chk("ovf_save_mem_addr", bus.mem_addr, 32'd254);
    chk("ovf_save_mem_rd", 32'(bus.mem_rd), 32'd1);
    chk("ovf_cause", 32'(bus.cause), 32'd2);
    chk("ovf_epc", bus.epc_out, 32'h40);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("ovf_busy_c3", 32'(bus.busy), 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("ovf_c4_ex_control", 32'(bus.ex_control), 32'd1);
    chk("ovf_c4_pc_write", 32'(bus.pc_write), 32'd1);
    chk("ovf_c4_handler", bus.handler_addr, 32'h0000_00A4);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("ovf_c5_busy", 32'(bus.busy), 32'd0);
    chk("ovf_c5_pc_write", 32'(bus.pc_write), 32'd0);

    // Simultaneous flags
    step(1'b1, 1'b1, 1'b1, 32'h0000_1000);
    chk("all_cause", 32'(bus.cause), 32'd1);
    chk("all_mem_addr", bus.mem_addr, 32'd253);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'd0);

    // Upper data bits ignored
    vec_word[255] = 32'hFFFF_FF10;
    step(1'b0, 1'b0, 1'b1, 32'h0000_2000);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("div0_handler", bus.handler_addr, 32'h0000_0010);
    chk("div0_cause", 32'(bus.cause), 32'd3);

    // Flag while busy is ignored
    pcw = 0;
    step(1'b1, 1'b0, 1'b0, 32'h0000_3000);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_4000);
    if (bus.pc_write) pcw++;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'd0);
      if (bus.pc_write) pcw++;
    end
    chk("busy_flag_cause", 32'(bus.cause), 32'd1);
    chk("busy_flag_epc", bus.epc_out, 32'h3000);
    chk("busy_flag_pcw_count", 32'(pcw), 32'd1);

    // Reset during WAIT
    pcw = 0;
    step(1'b0, 1'b1, 1'b0, 32'h0000_5000);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    mid_reset();
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_epc", bus.epc_out, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'd0);
      if (bus.pc_write) pcw++;
    end
    chk("rst_mid_no_pcw", 32'(pcw), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      f = (r < 20) ? 3'($urandom_range(1, 7)) : 3'd0;
      e = $urandom;
      if ($urandom_range(0, 9) == 0) vec_word[$urandom_range(253, 255)] = $urandom;
      step(f[2], f[1], f[0], e);
      if (r == 99) mid_reset();
    end

    // MEM_LATENCY=1 instance: JUMP three cycles after the trigger
    @(negedge clk);
    bus1.exc_div0 = 1'b1;
    bus1.epc_in = 32'h0000_ABC0;
    bus1.mem_data_in = 32'h1234_5655;
    jump_at = 0;
    pcw = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus1.exc_div0 = 1'b0;
        chk("lat1_save_mem_addr", bus1.mem_addr, 32'd255);
      end
      if (bus1.pc_write) begin
        pcw++;
        if (jump_at == 0) jump_at = i;
      end
    end
    chk("lat1_jump_cycle", 32'(jump_at), 32'd3);
    chk("lat1_pcw_count", 32'(pcw), 32'd1);
    chk("lat1_handler", bus1.handler_addr, 32'h0000_0055);
    chk("lat1_cause", 32'(bus1.cause), 32'd3);
    chk("lat1_epc", bus1.epc_out, 32'h0000_ABC0);
    chk("lat1_idle", 32'(bus1.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/exception_vector_unit.md
Name: exception_vector_unit

Overview:
- Sequences MIPS multicycle exception entry.
- On an exception cause it:
  - latches EPC and cause;
  - reads the handler vector byte from memory (address 253/254/255);
  - zero-extends that byte into handler_addr;
  - drives ex_control and pc_write so the downstream PC-select mux loads the handler address into PC.
- Sits between the datapath/main control and the PC-select mux; stalls the main control while active.

Parameters:
- VEC_OPCODE, 253, vector byte address for an unknown opcode.
- VEC_OVERFLOW, 254, vector byte address for arithmetic overflow.
- VEC_DIV0, 255, vector byte address for divide by zero.
- MEM_LATENCY, 2, cycles from the read request to valid mem_data_in (legal range 1..7).

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; forces IDLE and clears all outputs.
- exc_opcode  in  1  unknown-opcode flag; sampled only in IDLE.
- exc_overflow  in  1  overflow flag; sampled only in IDLE.
- exc_div0  in  1  divide-by-zero flag; sampled only in IDLE.
- epc_in  in  32  address of the faulting instruction.
- mem_data_in  in  32  memory read data; bits [7:0] hold the vector.
- mem_addr  out  32  vector address driven to memory.
- mem_rd  out  1  one-cycle read request.
- mem_addr_sel  out  1  1 = memory address mux takes mem_addr.
- epc_out  out  32  saved EPC.
- cause  out  2  00 none, 01 opcode, 10 overflow, 11 div0.
- handler_addr  out  32  zero-extended vector; feeds the memory-data input of the PC-select mux.
- ex_control  out  2  PC-select mux control: 00 normal PC source, 01 handler_addr.
- pc_write  out  1  one-cycle PC load strobe.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, wait counter=0, all outputs 0. Reset mid-sequence aborts immediately; no pc_write is issued afterwards.
- All outputs are registered (Moore). States: IDLE, SAVE, WAIT, JUMP.
- IDLE:
  - If any exception flag is 1 at a rising edge: latch epc_out<=epc_in and cause (priority opcode > overflow > div0), then go to SAVE.
  - Otherwise stay in IDLE; ex_control=00, pc_write=0.
- SAVE (1 cycle):
  - mem_addr = vector for the latched cause, zero-extended to 32 bits.
  - mem_rd=1, mem_addr_sel=1, busy=1.
  - Load wait counter with MEM_LATENCY-1; go to WAIT.
- WAIT (MEM_LATENCY cycles):
  - mem_addr and mem_addr_sel held; mem_rd=0.
  - Counter decrements each cycle.
  - At the edge where the counter is 0: handler_addr<={24'b0, mem_data_in[7:0]}, go to JUMP.
- JUMP (1 cycle):
  - ex_control=01, pc_write=1, mem_addr_sel=0.
  - Next edge: IDLE, with ex_control=00 and pc_write=0.
- Persistence after the sequence:
  - epc_out, cause and handler_addr hold until the next exception or reset.
  - mem_addr holds its last value.
- Latency: trigger edge to the JUMP cycle is 1+MEM_LATENCY+1 edges (4 for the default). Total busy time is MEM_LATENCY+2 cycles.
- Flags while busy: ignored and not queued. A flag still high on return to IDLE starts a new sequence (the main control must clear flags; the unit does not).
- Simultaneous flags: only the highest-priority cause is recorded and vectored.
- Vector byte: only bits [7:0] are used; upper data bits are ignored, so handler_addr is always <= 255.
- ex_control=10 and 11 are never driven.

Test Plan:
- Reset release with all flags 0 for 10 cycles -> every output 0, busy=0, ex_control=00.
- Overflow exception: pulse exc_overflow at edge 0 with epc_in=0x0000_0040; memory returns 0x0000_00A4 at address 254 -> cause=10, epc_out=0x40. SAVE cycle shows mem_addr=254, mem_rd=1. Cycle 4 shows ex_control=01, pc_write=1, handler_addr=0xA4. busy=1 for cycles 1..4; idle at cycle 5.
- Simultaneous flags: exc_opcode=exc_overflow=exc_div0=1 -> cause=01, mem_addr=253.
- Upper data bits ignored: mem_data_in=0xFFFF_FF10 -> handler_addr=0x0000_0010.
- Flags while busy: exc_div0 pulsed during WAIT -> ignored, cause unchanged, exactly one pc_write pulse.
- Reset mid-sequence: reset=0 during WAIT -> outputs clear immediately, no pc_write. With MEM_LATENCY=1, the JUMP cycle falls 3 edges after the trigger.
